// File: rtl/control_fifo1.sv
// control_fifo1: byte-in / 256-bit-word-out synchronous FIFO.
// Bytes pack little-endian into 32-byte words; level is counted in bytes.
//
// Ports:
//   clk            single clock, rising edge
//   rst_n          synchronous reset, active HIGH despite the name
//   dout           write byte
//   wrreq          write request (accepted when full=0)
//   ready          read request, pops one word (accepted when empty=0)
//   din            read word, updated one cycle after an accepted read
//   empty          no complete word stored
//   full           DEPTH_BYTES bytes stored
//   almost_empty   complete words <= AE_WORDS
//   almost_full    level >= AF_LEVEL
//   wr_water_level bytes stored, including a partially filled word
module control_fifo1 #(
    parameter int WR_WIDTH    = 8,
    parameter int RD_WIDTH    = 256,
    parameter int DEPTH_BYTES = 1024,
    parameter int AF_LEVEL    = 992,
    parameter int AE_WORDS    = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [WR_WIDTH-1:0] dout,
    input  logic                wrreq,
    input  logic                ready,
    output logic [RD_WIDTH-1:0] din,
    output logic                empty,
    output logic                full,
    output logic                almost_empty,
    output logic                almost_full,
    output logic [10:0]         wr_water_level
);

    localparam int BPW     = RD_WIDTH / WR_WIDTH;
    localparam int DEPTH_W = DEPTH_BYTES / BPW;
    localparam int LANE_W  = $clog2(BPW);
    localparam int ADDR_W  = $clog2(DEPTH_W);
    localparam int WP_W    = ADDR_W + LANE_W + 1;
    localparam int RP_W    = ADDR_W + 1;
    localparam int LVL_W   = WP_W;

    logic [RD_WIDTH-1:0] mem [DEPTH_W];

    logic [WP_W-1:0]   wp;
    logic [RP_W-1:0]   rp;
    logic [LVL_W-1:0]  level;
    logic [ADDR_W-1:0] wr_addr;
    logic [LANE_W-1:0] wr_lane;
    logic [ADDR_W-1:0] rd_addr;
    logic              wr_en;
    logic              rd_en;

    // Both pointers carry a wrap bit; scaling rp to bytes and
    // subtracting modulo 2^WP_W yields the byte fill level directly.
    assign level = wp - {rp, {LANE_W{1'b0}}};

    assign wr_water_level = level;

    assign empty        = (level < LVL_W'(BPW));
    assign full         = (level == LVL_W'(DEPTH_BYTES));
    assign almost_full  = (level >= LVL_W'(AF_LEVEL));
    assign almost_empty = ((level >> LANE_W) <= LVL_W'(AE_WORDS));

    assign wr_addr = wp[WP_W-2:LANE_W];
    assign wr_lane = wp[LANE_W-1:0];
    assign rd_addr = rp[RP_W-2:0];

    // Accept decisions use the current flags, so a same-cycle pop
    // never frees room for a write and a same-cycle 32nd byte never
    // makes a word poppable.
    assign wr_en = wrreq && !full && !rst_n;
    assign rd_en = ready && !empty && !rst_n;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            wp  <= '0;
            rp  <= '0;
            din <= '0;
        end else begin
            if (wr_en) begin
                wp <= wp + 1'b1;
            end
            if (rd_en) begin
                rp  <= rp + 1'b1;
                din <= mem[rd_addr];
            end
        end
    end

    // Storage is not reset; byte-lane write into the addressed word.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr][wr_lane*WR_WIDTH +: WR_WIDTH] <= dout;
        end
    end

endmodule

// File: tb/tb_control_fifo1.sv
// tb_control_fifo1: randomized checks of control_fifo1 against a
// byte-queue reference model.
module tb_control_fifo1;

    logic         clk;
    logic         rst_n;
    logic [7:0]   dout;
    logic         wrreq;
    logic         ready;
    logic [255:0] din;
    logic         empty;
    logic         full;
    logic         almost_empty;
    logic         almost_full;
    logic [10:0]  wr_water_level;

    int checks;
    int failures;

    logic [7:0]   mq[$];
    logic [255:0] exp_din;
    logic [7:0]   hist[256];

    control_fifo1 dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .dout           (dout),
        .wrreq          (wrreq),
        .ready          (ready),
        .din            (din),
        .empty          (empty),
        .full           (full),
        .almost_empty   (almost_empty),
        .almost_full    (almost_full),
        .wr_water_level (wr_water_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock: drive, take the edge, update the model, settle.
    task automatic step(input logic w, input logic [7:0] b,
                        input logic r, input logic rs);
        int lvl;
        bit wacc;
        bit racc;
        wrreq = w;
        dout  = b;
        ready = r;
        rst_n = rs;
        @(posedge clk);
        if (rs) begin
            mq.delete();
            exp_din = '0;
        end else begin
            lvl  = mq.size();
            wacc = w && (lvl < 1024);
            racc = r && (lvl >= 32);
            if (racc) begin
                for (int i = 0; i < 32; i++) begin
                    exp_din[i*8 +: 8] = mq.pop_front();
                end
            end
            if (wacc) mq.push_back(b);
        end
        #1;
        wrreq = 1'b0;
        ready = 1'b0;
        rst_n = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 10; i++) step(1'b0, 8'h00, 1'b0, 1'b1);
        checks++;
        if (empty !== 1'b1 || almost_empty !== 1'b1 || full !== 1'b0 ||
            almost_full !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags got e=%b ae=%b f=%b af=%b want 1 1 0 0",
                     empty, almost_empty, full, almost_full);
        end
        checks++;
        if (wr_water_level !== 11'd0) begin
            failures++;
            $display("FAIL reset_level got %0d want 0", wr_water_level);
        end
        checks++;
        if (din !== 256'd0) begin
            failures++;
            $display("FAIL reset_din got %h want 0", din);
        end
    endtask

    task automatic test_fill();
        int n;
        for (int i = 0; i < 256; i++) begin
            hist[i] = 8'($urandom_range(100, 0));
            step(1'b1, hist[i], 1'b0, 1'b0);
            n = i + 1;
            checks++;
            if (wr_water_level !== 11'(n)) begin
                failures++;
                $display("FAIL fill_level n=%0d got %0d want %0d",
                         n, wr_water_level, n);
            end
            checks++;
            if (empty !== (n < 32) || almost_empty !== (n < 64)) begin
                failures++;
                $display("FAIL fill_flags n=%0d got e=%b ae=%b want %b %b",
                         n, empty, almost_empty, n < 32, n < 64);
            end
        end
    endtask

    task automatic test_drain();
        logic [255:0] w8;
        for (int i = 0; i < 256; i++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0);
            checks++;
            if (din !== exp_din) begin
                failures++;
                $display("FAIL drain_din cyc=%0d got %h want %h",
                         i, din, exp_din);
            end
        end
        for (int j = 0; j < 32; j++) w8[j*8 +: 8] = hist[224 + j];
        checks++;
        if (din !== w8) begin
            failures++;
            $display("FAIL drain_word8 got %h want %h", din, w8);
        end
        checks++;
        if (empty !== 1'b1 || wr_water_level !== 11'd0) begin
            failures++;
            $display("FAIL drain_end got e=%b lvl=%0d want 1 0",
                     empty, wr_water_level);
        end
    endtask

    task automatic test_full();
        int n;
        for (int i = 0; i < 1024; i++) begin
            step(1'b1, 8'($urandom_range(100, 0)), 1'b0, 1'b0);
            n = i + 1;
            checks++;
            if (almost_full !== (n >= 992) || full !== (n == 1024)) begin
                failures++;
                $display("FAIL full_flags n=%0d got af=%b f=%b want %b %b",
                         n, almost_full, full, n >= 992, n == 1024);
            end
        end
        step(1'b1, 8'hff, 1'b0, 1'b0);
        checks++;
        if (wr_water_level !== 11'd1024 || full !== 1'b1) begin
            failures++;
            $display("FAIL overflow got lvl=%0d f=%b want 1024 1",
                     wr_water_level, full);
        end
        // Write while full, with a same-cycle read: write must drop.
        step(1'b1, 8'hfe, 1'b1, 1'b0);
        checks++;
        if (wr_water_level !== 11'd992 || din !== exp_din) begin
            failures++;
            $display("FAIL full_rw got lvl=%0d din=%h want 992 %h",
                     wr_water_level, din, exp_din);
        end
        for (int i = 0; i < 31; i++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0);
            checks++;
            if (din !== exp_din) begin
                failures++;
                $display("FAIL full_readback w=%0d got %h want %h",
                         i, din, exp_din);
            end
        end
        checks++;
        if (wr_water_level !== 11'd0 || empty !== 1'b1) begin
            failures++;
            $display("FAIL full_drained got lvl=%0d e=%b want 0 1",
                     wr_water_level, empty);
        end
    endtask

    task automatic test_simul();
        for (int i = 0; i < 100; i++) begin
            step(1'b1, 8'($urandom_range(255, 0)), 1'b0, 1'b0);
        end
        step(1'b1, 8'h5a, 1'b1, 1'b0);
        checks++;
        if (wr_water_level !== 11'd69) begin
            failures++;
            $display("FAIL simul_level got %0d want 69", wr_water_level);
        end
        checks++;
        if (din !== exp_din) begin
            failures++;
            $display("FAIL simul_din got %h want %h", din, exp_din);
        end
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 431; i++) begin
            step(1'b1, 8'($urandom_range(255, 0)), 1'b0, 1'b0);
        end
        checks++;
        if (wr_water_level !== 11'd500) begin
            failures++;
            $display("FAIL pre_reset_level got %0d want 500", wr_water_level);
        end
        step(1'b1, 8'h11, 1'b1, 1'b1);
        checks++;
        if (wr_water_level !== 11'd0 || din !== 256'd0 ||
            empty !== 1'b1 || almost_empty !== 1'b1 ||
            full !== 1'b0 || almost_full !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset got lvl=%0d din=%h e=%b ae=%b f=%b af=%b",
                     wr_water_level, din, empty, almost_empty, full, almost_full);
        end
        for (int i = 0; i < 31; i++) begin
            step(1'b1, 8'($urandom_range(255, 0)), 1'b0, 1'b0);
        end
        // 32nd byte and read together: read must drop.
        step(1'b1, 8'h77, 1'b1, 1'b0);
        checks++;
        if (wr_water_level !== 11'd32 || din !== 256'd0 || empty !== 1'b0) begin
            failures++;
            $display("FAIL edge_read got lvl=%0d e=%b din=%h want 32 0 0",
                     wr_water_level, empty, din);
        end
        step(1'b0, 8'h00, 1'b1, 1'b0);
        checks++;
        if (din !== exp_din || wr_water_level !== 11'd0) begin
            failures++;
            $display("FAIL restart_word got lvl=%0d din=%h want 0 %h",
                     wr_water_level, din, exp_din);
        end
    endtask

    task automatic test_random();
        int lvl;
        logic w;
        logic r;
        for (int i = 0; i < 3000; i++) begin
            w = ($urandom_range(99, 0) < 75);
            r = ($urandom_range(99, 0) < ((i / 500) % 2 == 0 ? 2 : 6));
            step(w, 8'($urandom_range(255, 0)), r, 1'b0);
            lvl = mq.size();
            checks++;
            if (wr_water_level !== 11'(lvl) || din !== exp_din ||
                empty !== (lvl < 32) || full !== (lvl == 1024) ||
                almost_full !== (lvl >= 992) ||
                almost_empty !== ((lvl / 32) <= 1)) begin
                failures++;
                $display("FAIL random cyc=%0d lvl=%0d/%0d e=%b f=%b af=%b ae=%b din_ok=%b",
                         i, wr_water_level, lvl, empty, full, almost_full,
                         almost_empty, din === exp_din);
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        exp_din  = '0;
        rst_n    = 1'b1;
        wrreq    = 1'b0;
        ready    = 1'b0;
        dout     = 8'h00;
        test_reset();
        test_fill();
        test_drain();
        test_full();
        test_simul();
        test_mid_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
